call_stack: RTL
===============

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DEPTH, default 16, number of return-address entries; power of two, 4..64.
REQ-002 Parameter AW, default 19, return-address width; matches CPU PC width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised to clk by the system.
REQ-005 push  input  1  push request, driven by the pipelined ID_push of a CALL.
REQ-006 pop  input  1  pop request, driven by the pipelined ID_pop of a RET.
REQ-007 stall  input  1  pipeline hold; when high, push and pop are ignored.
REQ-008 clear  input  1  synchronous flush of the whole stack.
REQ-009 push_addr  input  AW  return address (PC+1) to store on push.
REQ-010 ret_addr  output  AW  current top-of-stack address, used as the RET target.
REQ-011 ret_valid  output  1  high when the stack holds at least one entry.
REQ-012 full  output  1  high when depth equals DEPTH.
REQ-013 depth  output  log2(DEPTH)+1  current number of valid entries.
REQ-014 overflow  output  1  sticky error flag for a push that was dropped.
REQ-015 underflow  output  1  sticky error flag for a pop on an empty stack.

Function
REQ-016 Storage is a DEPTH x AW register array plus stack pointer sp (0..DEPTH); depth equals sp.
REQ-017 ret_addr equals entry[sp-1] combinationally from registered state; ret_addr is 0 when sp is 0.
REQ-018 ret_valid is (sp != 0); full is (sp == DEPTH).
REQ-019 Effective ops: p = push & ~stall, q = pop & ~stall, evaluated once per rising edge.
REQ-020 p only, not full: entry[sp] <= push_addr, sp <= sp+1; the new address is visible on ret_addr the next cycle (1-cycle latency).
REQ-021 p only, full: array and sp unchanged, overflow <= 1.
REQ-022 q only, not empty: sp <= sp-1; the entry is not erased.
REQ-023 q only, empty: sp stays 0, underflow <= 1.
REQ-024 p and q, not empty (including full): entry[sp-1] <= push_addr, sp unchanged, no flag set.
REQ-025 p and q, empty: entry[0] <= push_addr, sp <= 1, underflow <= 1.
REQ-026 stall high: no change to array, sp or flags, regardless of push and pop.
REQ-027 clear high: sp <= 0, overflow <= 0, underflow <= 0; clear overrides stall, push and pop; array contents are don't-care.
REQ-028 overflow and underflow remain set until clear or reset.
REQ-029 sp never wraps; all sp arithmetic is saturating per REQ-020..REQ-025.

Reset
REQ-030 While rst_n is low: sp = 0, overflow = 0, underflow = 0; outputs immediately read ret_valid = 0, full = 0, depth = 0, ret_addr = 0.
REQ-031 Reset asserted mid-push or mid-pop aborts the operation; array contents after reset are don't-care and must never be visible, because sp is 0.
REQ-032 The first edge after rst_n rises behaves as a normal cycle.

Verification
REQ-033 Reset, then push 0x00010, 0x00020, 0x00030 on consecutive cycles -> depth = 3, ret_addr = 0x00030; then three pops -> ret_addr 0x00020, 0x00010, then ret_valid = 0.
REQ-034 DEPTH = 16: 16 pushes of i+1 -> full = 1, ret_addr = 16; a 17th push of 0x7FFFF -> overflow = 1, depth = 16, ret_addr still 16.
REQ-035 Empty stack, pop -> underflow = 1, depth = 0; then clear -> underflow = 0.
REQ-036 depth = 2 with top 0x00100, then push = pop = 1 with push_addr 0x00200 -> depth = 2, ret_addr = 0x00200, no flags; same on empty stack -> depth = 1, ret_addr = 0x00200, underflow = 1.
REQ-037 stall = 1 with push = 1 for 3 cycles -> depth unchanged; clear and push in the same cycle -> depth = 0.
REQ-038 rst_n pulsed low between clock edges while depth = 5 -> depth = 0 and ret_valid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/call_stack.sv
// Hardware return-address stack for CALL/RET: a register array plus a
// saturating stack pointer, with sticky overflow/underflow error flags.
module call_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     stall,
  input  logic                     clear,
  input  logic [AW-1:0]            push_addr,
  output logic [AW-1:0]            ret_addr,
  output logic                     ret_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IW  = SPW - 1;

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic           pEff, qEff, empty, isFull, wrEn;
  logic [IW-1:0]  topIdx, wrIdx;

  assign pEff   = push & ~stall;
  assign qEff   = pop & ~stall;
  assign empty  = (sp_q == '0);
  assign isFull = (sp_q == SPW'(DEPTH));
  assign topIdx = IW'(sp_q - SPW'(1));

  // A simultaneous push/pop on a non-empty stack replaces the top entry in place.
  assign wrIdx = (qEff && !empty) ? topIdx : sp_q[IW-1:0];
  assign wrEn  = ~clear & pEff & (qEff | ~isFull);

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      sp_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (pEff && !qEff) begin
      if (isFull) overflow_d = 1'b1;
      else        sp_d       = sp_q + SPW'(1);
    end else if (qEff && !pEff) begin
      if (empty) underflow_d = 1'b1;
      else       sp_d        = sp_q - SPW'(1);
    end else if (pEff && qEff && empty) begin
      sp_d        = SPW'(1);
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entries are never cleared; sp alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrIdx] <= push_addr;
  end

  assign ret_addr  = empty ? '0 : mem_q[topIdx];
  assign ret_valid = ~empty;
  assign full      = isFull;
  assign depth     = sp_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
